// File: rtl/mux4a2_l1.sv
// 4-to-2 lane folding mux: one 4-lane word goes out over two clk_2f cycles,
// lanes 0/1 first then lanes 2/3, with a one-word holding register and in_ready handshake.
module mux4a2_l1 #(
  parameter int unsigned BW = 8
) (
  input  logic          clk_2f,
  input  logic          reset_L,
  input  logic [BW-1:0] data_in0,
  input  logic [BW-1:0] data_in1,
  input  logic [BW-1:0] data_in2,
  input  logic [BW-1:0] data_in3,
  input  logic          valid_in0,
  input  logic          valid_in1,
  input  logic          valid_in2,
  input  logic          valid_in3,
  output logic          in_ready,
  output logic [BW-1:0] data_out0,
  output logic [BW-1:0] data_out1,
  output logic          valid_out0,
  output logic          valid_out1,
  output logic          out_phase,
  output logic          err_drop
);

  typedef enum logic [1:0] {StIdle, StLo, StHi} state_e;

  state_e        state;
  logic [BW-1:0] hold_d0, hold_d1, hold_d2, hold_d3;
  logic [3:0]    hold_v;
  logic          hold_full;
  logic [BW-1:0] work_d2, work_d3;
  logic          work_v2, work_v3;

  logic any_valid;
  logic load;
  logic accept;

  always_comb begin
    any_valid = valid_in0 | valid_in1 | valid_in2 | valid_in3;
    load      = hold_full & ((state == StIdle) | (state == StHi));
    in_ready  = ~hold_full | load;
    accept    = in_ready & any_valid;
  end

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      state      <= StIdle;
      hold_d0    <= '0;
      hold_d1    <= '0;
      hold_d2    <= '0;
      hold_d3    <= '0;
      hold_v     <= '0;
      hold_full  <= 1'b0;
      work_d2    <= '0;
      work_d3    <= '0;
      work_v2    <= 1'b0;
      work_v3    <= 1'b0;
      data_out0  <= '0;
      data_out1  <= '0;
      valid_out0 <= 1'b0;
      valid_out1 <= 1'b0;
      out_phase  <= 1'b0;
      err_drop   <= 1'b0;
    end else begin
      // Invalid lanes are zeroed on capture so they drive 0 in their slot.
      if (accept) begin
        hold_d0   <= data_in0 & {BW{valid_in0}};
        hold_d1   <= data_in1 & {BW{valid_in1}};
        hold_d2   <= data_in2 & {BW{valid_in2}};
        hold_d3   <= data_in3 & {BW{valid_in3}};
        hold_v    <= {valid_in3, valid_in2, valid_in1, valid_in0};
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end

      if (any_valid && !in_ready) begin
        err_drop <= 1'b1;
      end

      case (state)
        StIdle, StHi: begin
          out_phase <= 1'b0;
          if (load) begin
            data_out0  <= hold_d0;
            data_out1  <= hold_d1;
            valid_out0 <= hold_v[0];
            valid_out1 <= hold_v[1];
            work_d2    <= hold_d2;
            work_d3    <= hold_d3;
            work_v2    <= hold_v[2];
            work_v3    <= hold_v[3];
            state      <= StLo;
          end else begin
            data_out0  <= '0;
            data_out1  <= '0;
            valid_out0 <= 1'b0;
            valid_out1 <= 1'b0;
            state      <= StIdle;
          end
        end
        StLo: begin
          data_out0  <= work_d2;
          data_out1  <= work_d3;
          valid_out0 <= work_v2;
          valid_out1 <= work_v3;
          out_phase  <= 1'b1;
          state      <= StHi;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mux4a2_l1.sv
// Self-checking bench for mux4a2_l1: directed steps plus random words checked
// against a queue-level reference model of the fold.
module tb_mux4a2_l1;

  logic       clk_2f = 1'b0;
  logic       reset_L;
  logic [7:0] data_in0, data_in1, data_in2, data_in3;
  logic       valid_in0, valid_in1, valid_in2, valid_in3;
  logic       in_ready;
  logic [7:0] data_out0, data_out1;
  logic       valid_out0, valid_out1, out_phase, err_drop;

  mux4a2_l1 #(.BW(8)) dut (
    .clk_2f    (clk_2f),
    .reset_L   (reset_L),
    .data_in0  (data_in0),
    .data_in1  (data_in1),
    .data_in2  (data_in2),
    .data_in3  (data_in3),
    .valid_in0 (valid_in0),
    .valid_in1 (valid_in1),
    .valid_in2 (valid_in2),
    .valid_in3 (valid_in3),
    .in_ready  (in_ready),
    .data_out0 (data_out0),
    .data_out1 (data_out1),
    .valid_out0(valid_out0),
    .valid_out1(valid_out1),
    .out_phase (out_phase),
    .err_drop  (err_drop)
  );

  always #5 clk_2f = ~clk_2f;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] d0;
    logic [7:0] d1;
    logic       v0;
    logic       v1;
    logic       ph;
  } half_t;

  // Reference model: one pending word slot and a queue of half-words still to appear.
  logic [7:0] mh[4];
  logic [3:0] mv;
  logic       m_full;
  logic       m_err;
  half_t      out_q[$];
  half_t      cur;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_ready();
    return !m_full || (out_q.size() == 0);
  endfunction

  task automatic model_reset();
    m_full = 1'b0;
    m_err  = 1'b0;
    mv     = '0;
    for (int i = 0; i < 4; i++) mh[i] = '0;
    out_q.delete();
    cur = '0;
  endtask

  task automatic model_edge(input logic [7:0] a, b, c, d, input logic [3:0] v);
    logic rdy;
    half_t h;
    rdy = m_ready();
    if (out_q.size() == 0 && m_full) begin
      h.d0 = mv[0] ? mh[0] : 8'h00; h.d1 = mv[1] ? mh[1] : 8'h00;
      h.v0 = mv[0]; h.v1 = mv[1]; h.ph = 1'b0;
      out_q.push_back(h);
      h.d0 = mv[2] ? mh[2] : 8'h00; h.d1 = mv[3] ? mh[3] : 8'h00;
      h.v0 = mv[2]; h.v1 = mv[3]; h.ph = 1'b1;
      out_q.push_back(h);
      m_full = 1'b0;
    end
    if (out_q.size() > 0) cur = out_q.pop_front();
    else cur = '0;
    if (v != 4'b0) begin
      if (rdy) begin
        mh[0] = a; mh[1] = b; mh[2] = c; mh[3] = d; mv = v; m_full = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".d0"}, data_out0, cur.d0);
    check({tag, ".d1"}, data_out1, cur.d1);
    check({tag, ".v0"}, valid_out0, cur.v0);
    check({tag, ".v1"}, valid_out1, cur.v1);
    check({tag, ".ph"}, out_phase, cur.ph);
    check({tag, ".err"}, err_drop, m_err);
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cycle(input string tag, input logic [7:0] a, b, c, d, input logic [3:0] v);
    data_in0 = a; data_in1 = b; data_in2 = c; data_in3 = d;
    {valid_in3, valid_in2, valid_in1, valid_in0} = v;
    #1;
    check({tag, ".rdy"}, in_ready, m_ready());
    @(posedge clk_2f);
    model_edge(a, b, c, d, v);
    #1;
    check_outputs(tag);
    @(negedge clk_2f);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w[4];
    logic [31:0] sent_q[$];
    logic [31:0] exp_w;
    logic [15:0] lo_part;
    int sent, halves;
    logic started, gap;

    model_reset();
    reset_L = 1'b0;
    data_in0 = 8'h00; data_in1 = 8'h00; data_in2 = 8'h00; data_in3 = 8'h00;
    {valid_in3, valid_in2, valid_in1, valid_in0} = 4'b0000;

    // Reset held over two edges with toggling inputs.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_2f);
      data_in0 = 8'($urandom); data_in1 = 8'($urandom);
      data_in2 = 8'($urandom); data_in3 = 8'($urandom);
      {valid_in3, valid_in2, valid_in1, valid_in0} = 4'b1111;
      @(posedge clk_2f); #1;
      check_outputs("rst");
    end
    @(negedge clk_2f);
    {valid_in3, valid_in2, valid_in1, valid_in0} = 4'b0000;
    reset_L = 1'b1;
    #1;
    check("rst.in_ready", in_ready, 1'b1);
    idle("rst_idle", 1);

    // Single word: lanes 0/1 one edge after accept, lanes 2/3 the next.
    cycle("single_acc", 8'h10, 8'h08, 8'h1F, 8'h11, 4'b1111);
    idle("single_lo", 1);
    check("single.lo", {data_out0, data_out1, valid_out0, valid_out1, out_phase},
          {8'h10, 8'h08, 3'b110});
    idle("single_hi", 1);
    check("single.hi", {data_out0, data_out1, valid_out0, valid_out1, out_phase},
          {8'h1F, 8'h11, 3'b111});
    idle("single_end", 1);
    check("single.end", {data_out0, data_out1, valid_out0, valid_out1, out_phase}, 19'd0);
    idle("single_drain", 1);

    // Streaming: offer whenever ready, reassemble and check for gaps.
    sent = 0; halves = 0; started = 1'b0; gap = 1'b0; lo_part = '0;
    for (int i = 0; i < 40 && halves < 16; i++) begin
      if (sent < 8 && in_ready) begin
        for (int k = 0; k < 4; k++) w[k] = 8'($urandom);
        sent_q.push_back({w[3], w[2], w[1], w[0]});
        sent++;
        cycle("stream", w[0], w[1], w[2], w[3], 4'b1111);
      end else begin
        cycle("stream", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
      end
      if (valid_out0) begin
        started = 1'b1;
        halves++;
        if (!out_phase) begin
          lo_part = {data_out1, data_out0};
        end else begin
          exp_w = (sent_q.size() > 0) ? sent_q.pop_front() : 32'hDEAD_BEEF;
          check("stream.word", {data_out1, data_out0, lo_part}, exp_w);
        end
      end else if (started) begin
        gap = 1'b1;
      end
    end
    check("stream.sent", sent, 8);
    check("stream.halves", halves, 16);
    check("stream.nogap", gap, 1'b0);
    idle("stream_drain", 2);

    // Partial valid: invalid lanes keep their slot but drive 0.
    cycle("part_acc", 8'h23, 8'h55, 8'h2D, 8'h66, 4'b0101);
    idle("part_lo", 1);
    check("part.lo", {data_out0, data_out1, valid_out0, valid_out1}, {8'h23, 8'h00, 2'b10});
    idle("part_hi", 1);
    check("part.hi", {data_out0, data_out1, valid_out0, valid_out1}, {8'h2D, 8'h00, 2'b10});
    idle("part_drain", 2);

    // Overflow: a word every cycle; err_drop must latch and stay set.
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < 4; k++) w[k] = 8'($urandom);
      cycle("ovf", w[0], w[1], w[2], w[3], 4'b1111);
    end
    check("ovf.err", err_drop, 1'b1);
    idle("ovf_drain", 4);
    check("ovf.sticky", err_drop, 1'b1);

    // Reset with a word in LO and another held: both must vanish.
    cycle("rlo_w0", 8'hA1, 8'hA2, 8'hA3, 8'hA4, 4'b1111);
    cycle("rlo_w1", 8'hB1, 8'hB2, 8'hB3, 8'hB4, 4'b1111);
    check("rlo.in_lo", {valid_out0, out_phase}, 2'b10);
    reset_L = 1'b0;
    model_reset();
    #1;
    check_outputs("rlo_async");
    @(posedge clk_2f);
    @(negedge clk_2f);
    reset_L = 1'b1;
    idle("rlo_after", 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
